// File: rtl/cpu_lsu_pkg.sv
// Shared types and request checking for the cpu_lsu load/store unit.
package cpu_lsu_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11} size_e;

  typedef enum logic [2:0] {IDLE, READ, WRITE, WB, ERR} state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Earlier tests win: an illegal size hides misalignment, which hides range.
  function automatic logic [1:0] req_check(input size_e size, input logic [31:0] addr);
    if (size == SZ_X) return ERR_SIZE;
    if ((size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00)) return ERR_MISALIGN;
    if (addr[31:12] != 20'd0) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import cpu_lsu_pkg::*;
(
  input  size_e       size,
  input  logic        zext,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] shifted;
  logic [15:0] half_sel;

  assign shifted  = old_word >> {lane, 3'b000};
  assign half_sel = lane[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    load_data  = old_word;
    merge_data = wdata;
    case (size)
      SZ_B: begin
        load_data  = zext ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        merge_data = old_word;
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data  = zext ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_data = old_word;
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_lsu.sv
// Multi-cycle load/store unit: request latch, error check, RMW for sub-word stores,
// and register-file writeback of extended load data.
module cpu_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_writeen,
  output logic [31:0]       mem_writeint,
  input  logic [31:0]       mem_rd,
  output logic              wb_writeen,
  output logic [4:0]        wb_addrw,
  output logic [31:0]       wb_writeint,
  output logic              err_valid,
  output logic [1:0]        err_cause
);

  state_e      state, state_nxt;
  logic        we_q, zext_q;
  size_e       size_q;
  logic [1:0]  lane_q, cause_q, req_cause;
  logic [31:0] wdata_q, old_q, load_data, merge_data;
  logic [4:0]  rd_q;
  logic        accept;

  assign accept    = req_valid && (state == IDLE);
  assign req_cause = req_check(size_e'(req_size), req_addr);
  assign wb_addrw  = rd_q;

  lsu_align u_align (
    .size       (size_q),
    .zext       (zext_q),
    .lane       (lane_q),
    .old_word   (old_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      size_q   <= SZ_B;
      lane_q   <= 2'd0;
      cause_q  <= ERR_NONE;
      wdata_q  <= 32'd0;
      old_q    <= 32'd0;
      rd_q     <= 5'd0;
      mem_addr <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q     <= req_we;
        zext_q   <= req_unsigned;
        size_q   <= size_e'(req_size);
        lane_q   <= req_addr[1:0];
        cause_q  <= req_cause;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        mem_addr <= req_addr[ADDR_W+1:2];
      end
      if (state == READ) old_q <= mem_rd;
    end
  end

  // Outputs decode from the state register so reset drops mem_writeen immediately.
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    mem_writeen  = 1'b0;
    mem_writeint = 32'd0;
    wb_writeen   = 1'b0;
    wb_writeint  = 32'd0;
    err_valid    = 1'b0;
    err_cause    = ERR_NONE;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_cause != ERR_NONE)                           state_nxt = ERR;
          else if (req_we && size_e'(req_size) == SZ_W)        state_nxt = WRITE;
          else                                                 state_nxt = READ;
        end
      end
      READ:  state_nxt = we_q ? WRITE : WB;
      WRITE: begin
        mem_writeen  = 1'b1;
        mem_writeint = merge_data;
        state_nxt    = IDLE;
      end
      WB: begin
        wb_writeen  = (rd_q != 5'd0);
        wb_writeint = load_data;
        state_nxt   = IDLE;
      end
      ERR: begin
        err_valid = 1'b1;
        err_cause = cause_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu with a behavioural word memory behind the unit.
module tb_cpu_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [9:0]  mem_addr;
  logic        mem_writeen, wb_writeen, err_valid;
  logic [31:0] mem_writeint, mem_rd, wb_writeint;
  logic [4:0]  wb_addrw;
  logic [1:0]  err_cause;

  cpu_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_writeen(mem_writeen), .mem_writeint(mem_writeint),
    .mem_rd(mem_rd), .wb_writeen(wb_writeen), .wb_addrw(wb_addrw),
    .wb_writeint(wb_writeint), .err_valid(err_valid), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_writeen) mem[mem_addr] <= mem_writeint;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [7:0]  wb_m;
    logic [7:0]  wr_m;
    logic [7:0]  err_m;
    int          rdy;
    logic [31:0] val;
    logic [1:0]  cause;
  } vec_t;

  int total = 0, bad = 0;
  logic [7:0]  wb_m, wr_m, err_m;
  int          rdy_c;
  logic [31:0] wb_d, wr_d;
  logic [4:0]  wb_a;
  logic [1:0]  cz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic u, logic [31:0] a,
                              logic [31:0] wd, logic [4:0] rd, logic [7:0] wbm, logic [7:0] wrm,
                              logic [7:0] erm, int rdy, logic [31:0] val, logic [1:0] cause);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rd = rd;
    v.wb_m = wbm; v.wr_m = wrm; v.err_m = erm; v.rdy = rdy; v.val = val; v.cause = cause;
    return v;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drive(input vec_t v);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
  endtask

  // Cycle c (1..ncyc) is the cycle after the c-th rising edge following acceptance.
  task automatic observe(input int ncyc, input bit hold);
    wb_m = 8'd0; wr_m = 8'd0; err_m = 8'd0; rdy_c = 0;
    wb_d = 32'd0; wr_d = 32'd0; wb_a = 5'd0; cz = 2'd0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (hold && rdy_c != 0 && c > rdy_c) req_valid = 1'b0;
      if (wb_writeen)  begin wb_m[c] = 1'b1; wb_d = wb_writeint; wb_a = wb_addrw; end
      if (mem_writeen) begin wr_m[c] = 1'b1; wr_d = mem_writeint; end
      if (err_valid)   begin err_m[c] = 1'b1; cz = err_cause; end
      if (req_ready && rdy_c == 0) rdy_c = c;
    end
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    observe(6, 1'b0);
    check({v.name, "_wb_cycles"},  {24'd0, wb_m},  {24'd0, v.wb_m});
    check({v.name, "_wr_cycles"},  {24'd0, wr_m},  {24'd0, v.wr_m});
    check({v.name, "_err_cycles"}, {24'd0, err_m}, {24'd0, v.err_m});
    check({v.name, "_ready_back"}, rdy_c, v.rdy);
    if (v.wb_m != 8'd0) begin
      check({v.name, "_wb_data"}, wb_d, v.val);
      check({v.name, "_wb_addr"}, {27'd0, wb_a}, {27'd0, v.rd});
    end
    if (v.wr_m != 8'd0)  check({v.name, "_wr_data"}, wr_d, v.val);
    if (v.err_m != 8'd0) check({v.name, "_cause"}, {30'd0, cz}, {30'd0, v.cause});
  endtask

  vec_t vt[17];
  vec_t v;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0] = 32'd49; mem[1] = 32'd7; mem[2] = 32'd2;

    vt[0]  = mk("ld_w4",     0, 2'b10, 0, 32'h4,    32'h0,        5'd5, 8'h04, 8'h00, 8'h00, 3, 32'h0000_0007, 2'b00);
    vt[1]  = mk("st_w0",     1, 2'b10, 0, 32'h0,    32'h80FF_1234, 5'd0, 8'h00, 8'h02, 8'h00, 2, 32'h80FF_1234, 2'b00);
    vt[2]  = mk("ld_b2s",    0, 2'b00, 0, 32'h2,    32'h0,        5'd1, 8'h04, 8'h00, 8'h00, 3, 32'hFFFF_FFFF, 2'b00);
    vt[3]  = mk("ld_h2u",    0, 2'b01, 1, 32'h2,    32'h0,        5'd2, 8'h04, 8'h00, 8'h00, 3, 32'h0000_80FF, 2'b00);
    vt[4]  = mk("ld_h0s",    0, 2'b01, 0, 32'h0,    32'h0,        5'd3, 8'h04, 8'h00, 8'h00, 3, 32'h0000_1234, 2'b00);
    vt[5]  = mk("st_b9",     1, 2'b00, 0, 32'h9,    32'h0000_00AB, 5'd0, 8'h00, 8'h04, 8'h00, 3, 32'h0000_AB02, 2'b00);
    vt[6]  = mk("ld_w8",     0, 2'b10, 0, 32'h8,    32'h0,        5'd4, 8'h04, 8'h00, 8'h00, 3, 32'h0000_AB02, 2'b00);
    vt[7]  = mk("st_w6",     1, 2'b10, 0, 32'h6,    32'hDEAD_BEEF, 5'd0, 8'h00, 8'h00, 8'h02, 2, 32'h0,         2'b01);
    vt[8]  = mk("ld_range",  0, 2'b10, 0, 32'h1000, 32'h0,        5'd7, 8'h00, 8'h00, 8'h02, 2, 32'h0,         2'b10);
    vt[9]  = mk("sz_ill",    0, 2'b11, 0, 32'h0,    32'h0,        5'd8, 8'h00, 8'h00, 8'h02, 2, 32'h0,         2'b11);
    vt[10] = mk("sz_pri",    1, 2'b11, 0, 32'h1001, 32'h0,        5'd0, 8'h00, 8'h00, 8'h02, 2, 32'h0,         2'b11);
    vt[11] = mk("mis_pri",   0, 2'b10, 0, 32'h1002, 32'h0,        5'd9, 8'h00, 8'h00, 8'h02, 2, 32'h0,         2'b01);
    vt[12] = mk("ld_rd0",    0, 2'b10, 0, 32'h4,    32'h0,        5'd0, 8'h00, 8'h00, 8'h00, 3, 32'h0,         2'b00);
    vt[13] = mk("st_h2",     1, 2'b01, 0, 32'h2,    32'hFFFF_5566, 5'd0, 8'h00, 8'h04, 8'h00, 3, 32'h5566_1234, 2'b00);
    vt[14] = mk("ld_b3u",    0, 2'b00, 1, 32'h3,    32'h0,        5'd9, 8'h04, 8'h00, 8'h00, 3, 32'h0000_0055, 2'b00);
    vt[15] = mk("ld_h1_mis", 0, 2'b01, 0, 32'h1,    32'h0,        5'd9, 8'h00, 8'h00, 8'h02, 2, 32'h0,         2'b01);
    vt[16] = mk("ld_b1s",    0, 2'b00, 0, 32'h1,    32'h0,        5'd10, 8'h04, 8'h00, 8'h00, 3, 32'h0000_0012, 2'b00);

    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_ctl", {28'd0, mem_writeen, wb_writeen, err_valid, 1'b0}, 32'd0);
    check("rst_data", {mem_writeint | wb_writeint}, 32'd0);
    check("rst_misc", {20'd0, mem_addr, wb_addrw, err_cause} , 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vt[i]);

    // Store then load with req_valid held: the load is taken the cycle req_ready rises.
    wait_ready();
    v = mk("b2b_st", 1, 2'b10, 0, 32'hC, 32'h1234_5678, 5'd0, 8'h0, 8'h0, 8'h0, 0, 32'h0, 2'b00);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    v = mk("b2b_ld", 0, 2'b10, 0, 32'hC, 32'h0, 5'd6, 8'h0, 8'h0, 8'h0, 0, 32'h0, 2'b00);
    drive(v);
    observe(6, 1'b1);
    req_valid = 1'b0;
    check("b2b_wr_cycles", {24'd0, wr_m}, 32'h02);
    check("b2b_ready_back", rdy_c, 2);
    check("b2b_wb_cycles", {24'd0, wb_m}, 32'h10);
    check("b2b_wb_data", wb_d, 32'h1234_5678);
    check("b2b_wb_addr", {27'd0, wb_a}, 32'd6);

    // Reset during the WRITE of a byte store must abort without touching memory.
    wait_ready();
    v = mk("rst_st", 1, 2'b00, 0, 32'h4, 32'h0000_0077, 5'd0, 8'h0, 8'h0, 8'h0, 0, 32'h0, 2'b00);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_st_read_no_wr", {31'd0, mem_writeen}, 32'd0);
    @(negedge clk);
    check("rst_st_write_cycle", {31'd0, mem_writeen}, 32'd1);
    check("rst_st_merged", mem_writeint, 32'h0000_0077);
    rst_n = 1'b0;
    #1;
    check("rst_mid_writeen", {31'd0, mem_writeen}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_outputs", mem_writeint | wb_writeint | {22'd0, mem_addr} | {27'd0, wb_addrw}, 32'd0);
    check("rst_mid_flags", {29'd0, wb_writeen, err_valid, |err_cause}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mem_unchanged", mem[1], 32'h0000_0007);
    @(negedge clk);
    check("rst_release_ready", {31'd0, req_ready}, 32'd1);
    run_vec(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
